// File: rtl/bus_xbar_n.sv
// Single-master, N-slave registered bus decoder with wait states, timeout and access faults.
// Optional fault capture (err_addr/err_count) is built when BUS_ERR_CAPTURE_EN is defined.
module bus_xbar_n #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_SLAVES     = 5,
    parameter logic [NUM_SLAVES*XLEN-1:0] SLAVE_BASE = {
        32'h8000_0000, 32'h1000_0000, 32'h0C00_0000, 32'h0200_0000, 32'h0000_0000
    },
    parameter logic [NUM_SLAVES*XLEN-1:0] SLAVE_MASK = {
        32'hFFF0_0000, 32'hFFFF_F000, 32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_0000
    },
    parameter logic [NUM_SLAVES-1:0] SLAVE_RO = 5'b00001,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     m_req_valid,
    input  logic [XLEN-1:0]          m_req_addr,
    input  logic [63:0]              m_req_wdata,
    input  logic                     m_req_we,
    input  logic [2:0]               m_req_size,
    output logic                     m_req_ready,
    output logic                     m_rsp_valid,
    output logic [63:0]              m_rsp_rdata,
    output logic                     m_rsp_err,
    output logic [NUM_SLAVES-1:0]    s_req_valid,
    output logic [XLEN-1:0]          s_req_addr,
    output logic [63:0]              s_req_wdata,
    output logic                     s_req_we,
    output logic [2:0]               s_req_size,
    input  logic [NUM_SLAVES-1:0]    s_req_ready,
    input  logic [NUM_SLAVES*64-1:0] s_rsp_rdata,
    output logic [XLEN-1:0]          err_addr,
    output logic [15:0]              err_count
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [2:0]            size_q, size_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [NUM_SLAVES-1:0] match_oh;
    logic                  match_found;
    logic [63:0]           sel_rdata;
    logic                  sel_ready;
    logic                  req_fault;

    // Lowest-index matching slave wins.
    always_comb begin
        match_oh    = '0;
        match_found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!match_found &&
                ((m_req_addr & SLAVE_MASK[i*XLEN +: XLEN]) == SLAVE_BASE[i*XLEN +: XLEN])) begin
                match_oh[i] = 1'b1;
                match_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rsp_rdata[i*64 +: 64];
            end
        end
    end

    assign sel_ready = |(s_req_ready & sel_q);
    assign req_fault = !match_found || (m_req_we && |(match_oh & SLAVE_RO));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (m_req_valid) begin
                    addr_d  = m_req_addr;
                    wdata_d = m_req_wdata;
                    we_d    = m_req_we;
                    size_d  = m_req_size;
                    sel_d   = match_oh;
                    cnt_d   = '0;
                    if (req_fault) begin
                        // Faulting requests never reach a slave.
                        state_d = StResp;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (sel_ready) begin
                    state_d = StResp;
                    rdata_d = we_q ? 64'd0 : sel_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign m_req_ready = (state_q == StIdle);
    assign m_rsp_valid = (state_q == StResp);
    assign m_rsp_rdata = m_rsp_valid ? rdata_q : 64'd0;
    assign m_rsp_err   = m_rsp_valid && err_q;
    assign s_req_valid = (state_q == StBusy) ? sel_q : '0;
    assign s_req_addr  = addr_q;
    assign s_req_wdata = wdata_q;
    assign s_req_we    = we_q;
    assign s_req_size  = size_q;

`ifdef BUS_ERR_CAPTURE_EN
    logic [XLEN-1:0] err_addr_q;
    logic [15:0]     err_count_q;
    logic            err_event;

    // Every fault response is entered from IDLE or BUSY, so this fires once per fault.
    assign err_event = (state_d == StResp) && err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else if (err_event) begin
            err_addr_q <= addr_d;
            if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
`else
    assign err_addr  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_bus_xbar_n.sv
// Randomised self-checking bench for bus_xbar_n against a transaction-level model.
// Checks err_addr/err_count against the model when BUS_ERR_CAPTURE_EN is defined.
module tb_bus_xbar_n;

    localparam int NS = 5;
    localparam int TO = 16;
    localparam logic [31:0] BASE_A [NS] = '{
        32'h0000_0000, 32'h0200_0000, 32'h0C00_0000, 32'h1000_0000, 32'h8000_0000
    };
    localparam logic [31:0] MASK_A [NS] = '{
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFC00_0000, 32'hFFFF_F000, 32'hFFF0_0000
    };
    localparam logic [NS-1:0] RO = 5'b00001;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            m_req_valid = 1'b0;
    logic [31:0]     m_req_addr = '0;
    logic [63:0]     m_req_wdata = '0;
    logic            m_req_we = 1'b0;
    logic [2:0]      m_req_size = '0;
    logic            m_req_ready;
    logic            m_rsp_valid;
    logic [63:0]     m_rsp_rdata;
    logic            m_rsp_err;
    logic [NS-1:0]   s_req_valid;
    logic [31:0]     s_req_addr;
    logic [63:0]     s_req_wdata;
    logic            s_req_we;
    logic [2:0]      s_req_size;
    logic [NS-1:0]   s_req_ready = '0;
    logic [NS*64-1:0] s_rsp_rdata = '0;
    logic [31:0]     err_addr;
    logic [15:0]     err_count;

    always #5 clk = ~clk;

    bus_xbar_n #(
        .XLEN(32),
        .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .m_req_valid(m_req_valid),
        .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata),
        .m_req_we(m_req_we),
        .m_req_size(m_req_size),
        .m_req_ready(m_req_ready),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err),
        .s_req_valid(s_req_valid),
        .s_req_addr(s_req_addr),
        .s_req_wdata(s_req_wdata),
        .s_req_we(s_req_we),
        .s_req_size(s_req_size),
        .s_req_ready(s_req_ready),
        .s_rsp_rdata(s_rsp_rdata),
        .err_addr(err_addr),
        .err_count(err_count)
    );

    int total = 0;
    int bad = 0;

    // Expected outputs for the current cycle, written by the driver from the model.
    logic          chk_en = 1'b0;
    logic          exp_ready;
    logic [NS-1:0] exp_svalid;
    logic          exp_rsp_valid;
    logic [63:0]   exp_rdata;
    logic          exp_err;
    logic          exp_sreq_chk;
    logic [31:0]   exp_addr;
    logic [63:0]   exp_wdata;
    logic          exp_we;
    logic [2:0]    exp_size;
    logic [31:0]   m_err_addr = '0;
    logic [15:0]   m_err_count = '0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_req_ready", 64'(m_req_ready), 64'(exp_ready));
            cmp("s_req_valid", 64'(s_req_valid), 64'(exp_svalid));
            cmp("m_rsp_valid", 64'(m_rsp_valid), 64'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                cmp("m_rsp_rdata", m_rsp_rdata, exp_rdata);
                cmp("m_rsp_err", 64'(m_rsp_err), 64'(exp_err));
            end
            if (exp_sreq_chk) begin
                cmp("s_req_addr", 64'(s_req_addr), 64'(exp_addr));
                cmp("s_req_wdata", s_req_wdata, exp_wdata);
                cmp("s_req_we", 64'(s_req_we), 64'(exp_we));
                cmp("s_req_size", 64'(s_req_size), 64'(exp_size));
            end
`ifdef BUS_ERR_CAPTURE_EN
            cmp("err_addr", 64'(err_addr), 64'(m_err_addr));
            cmp("err_count", 64'(err_count), 64'(m_err_count));
`else
            cmp("err_addr", 64'(err_addr), 64'd0);
            cmp("err_count", 64'(err_count), 64'd0);
`endif
        end
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & MASK_A[i]) == BASE_A[i]) return i;
        end
        return -1;
    endfunction

    task automatic exp_idle();
        exp_ready     = 1'b1;
        exp_svalid    = '0;
        exp_rsp_valid = 1'b0;
        exp_sreq_chk  = 1'b0;
    endtask

    task automatic exp_reset_state();
        exp_idle();
        exp_sreq_chk = 1'b1;
        exp_addr     = '0;
        exp_wdata    = '0;
        exp_we       = 1'b0;
        exp_size     = '0;
    endtask

    task automatic rand_slaves();
        s_req_ready = NS'($urandom);
        for (int i = 0; i < NS; i++) s_rsp_rdata[i*64 +: 64] = {$urandom, $urandom};
    endtask

    // Request inputs outside IDLE must be ignored, so drive noise there.
    task automatic garbage_req();
        m_req_valid = 1'($urandom);
        m_req_addr  = $urandom;
        m_req_wdata = {$urandom, $urandom};
        m_req_we    = 1'($urandom);
        m_req_size  = 3'($urandom);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            m_req_valid = 1'b0;
            rand_slaves();
            exp_idle();
        end
    endtask

    // One transaction: selected slave becomes ready on BUSY cycle w+1 (w wait cycles).
    task automatic xact(input logic [31:0] a, input logic we, input logic [2:0] sz,
                        input logic [63:0] wd, input int w, input logic [63:0] rd);
        int sel;
        logic fault;
        int len;
        logic rsp_err;
        logic [63:0] rsp_data;
        logic [NS-1:0] oh;
        sel   = decode(a);
        fault = 1'b1;
        if (sel >= 0) fault = we && RO[sel];
        @(posedge clk); #1;
        m_req_valid = 1'b1;
        m_req_addr  = a;
        m_req_wdata = wd;
        m_req_we    = we;
        m_req_size  = sz;
        rand_slaves();
        exp_idle();
        if (!fault) begin
            len     = (w + 1 <= TO) ? w + 1 : TO;
            rsp_err = (w + 1 > TO);
            oh      = '0;
            oh[sel] = 1'b1;
            for (int k = 1; k <= len; k++) begin
                @(posedge clk); #1;
                garbage_req();
                rand_slaves();
                s_req_ready[sel] = (k == w + 1);
                s_rsp_rdata[sel*64 +: 64] = rd;
                exp_ready     = 1'b0;
                exp_svalid    = oh;
                exp_rsp_valid = 1'b0;
                exp_sreq_chk  = 1'b1;
                exp_addr      = a;
                exp_wdata     = wd;
                exp_we        = we;
                exp_size      = sz;
            end
            rsp_data = (rsp_err || we) ? 64'd0 : rd;
        end else begin
            rsp_err  = 1'b1;
            rsp_data = '0;
        end
        @(posedge clk); #1;
        garbage_req();
        rand_slaves();
        if (rsp_err) begin
            m_err_addr = a;
            if (m_err_count != 16'hFFFF) m_err_count = m_err_count + 16'd1;
        end
        exp_ready     = 1'b0;
        exp_svalid    = '0;
        exp_rsp_valid = 1'b1;
        exp_rdata     = rsp_data;
        exp_err       = rsp_err;
        exp_sreq_chk  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        if ($urandom % 4 == 0) return $urandom;
        k = int'($urandom % NS);
        return BASE_A[k] | ($urandom & ~MASK_A[k]);
    endfunction

    initial begin
        exp_reset_state();
        exp_rdata = '0;
        exp_err   = 1'b0;
        chk_en    = 1'b1;

        // Model pins: decode targets for the addresses used below.
        cmp("dec_dmem", 64'(decode(32'h8000_0010)), 64'(4));
        cmp("dec_clint", 64'(decode(32'h0200_BFF8)), 64'(1));
        cmp("dec_imem", 64'(decode(32'h0000_0100)), 64'(0));
        cmp("dec_unmapped", 64'(decode(32'h4000_0000)), 64'(-1));
        cmp("dec_uart", 64'(decode(32'h1000_0005)), 64'(3));
        cmp("dec_plic", 64'(decode(32'h0C00_0004)), 64'(2));

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        xact(32'h8000_0010, 1'b0, 3'd3, 64'h0, 0, 64'h1122_3344_5566_7788);
        xact(32'h0200_BFF8, 1'b0, 3'd3, 64'h0, 3, 64'hCAFE_F00D_DEAD_BEEF);
        xact(32'h0000_0100, 1'b1, 3'd2, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        exp_idle();
`ifdef BUS_ERR_CAPTURE_EN
        #1 cmp("first_fault_count", 64'(err_count), 64'd1);
        cmp("first_fault_addr", 64'(err_addr), 64'h0000_0100);
`endif
        xact(32'h4000_0000, 1'b0, 3'd2, 64'h0, 0, 64'h5555_5555_5555_5555);
        xact(32'h1000_0005, 1'b0, 3'd0, 64'h0, 1, 64'h0000_0000_0000_00A5);
        xact(32'h0C00_0004, 1'b0, 3'd2, 64'h0, 1000, 64'h7777_7777_7777_7777);
        xact(32'h0C00_0004, 1'b0, 3'd2, 64'h0, TO - 1, 64'h8888_8888_8888_8888);
        xact(32'h8000_0100, 1'b1, 3'd3, 64'hFEDC_BA98_7654_3210, 2, 64'h9999_9999_9999_9999);
        idle(1);

        // Reset in the middle of a BUSY wait: no response must ever appear.
        @(posedge clk); #1;
        m_req_valid = 1'b1;
        m_req_addr  = 32'h0C00_0004;
        m_req_we    = 1'b0;
        m_req_size  = 3'd2;
        m_req_wdata = 64'h0;
        s_req_ready = '0;
        exp_idle();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            m_req_valid   = 1'b0;
            s_req_ready   = '0;
            exp_ready     = 1'b0;
            exp_svalid    = 5'b00100;
            exp_rsp_valid = 1'b0;
            exp_sreq_chk  = 1'b1;
            exp_addr      = 32'h0C00_0004;
            exp_wdata     = 64'h0;
            exp_we        = 1'b0;
            exp_size      = 3'd2;
        end
        @(posedge clk); #1;
        reset_n     = 1'b0;
        s_req_ready = '1;
        m_err_addr  = '0;
        m_err_count = '0;
        exp_reset_state();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n     = 1'b1;
        s_req_ready = '0;
        repeat (3) begin
            @(posedge clk); #1;
            exp_reset_state();
        end

        for (int t = 0; t < 300; t++) begin
            int w;
            if ($urandom % 8 == 0) w = TO - 1 + int'($urandom % 3);
            else w = int'($urandom % 4);
            xact(rand_addr(), 1'($urandom), 3'($urandom % 4), {$urandom, $urandom}, w,
                 {$urandom, $urandom});
            if ($urandom % 3 == 0) idle(int'($urandom % 3) + 1);
        end
        idle(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
